demux_1to10: RTL and testbench

DEMUX_1TO10 -- requirements
Module: demux_1to10

---
 rtl/demux_1to10.sv | 100 ++++++++++
 tb/tb_demux_1to10.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1to10.sv
// demux_1to10: single-entry 1-to-10 router.
// One held word (data + channel select) is presented on a shared data bus with a
// one-hot valid per channel. Words with a select of 10..15 are dropped and counted.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready, and a
// held word is delivered on a rising edge where out_valid[k] && out_ready[k]. The
// producer may not rely on in_ready before driving in_valid; the consumer of
// channel k sees out_valid[k] stay high with out_data stable until it takes the word.
module demux_1to10 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [9:0]       out_valid,
  input  logic [9:0]       out_ready,
  output logic             err_sel,
  output logic [7:0]       err_count,
  output logic             dbg_full
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       sel_q, sel_d;
  logic             err_sel_q, err_sel_d;
  logic [7:0]       err_count_q, err_count_d;

  logic deliver;
  logic accept;
  logic legal;

  // Decode the held select into the one-hot channel valid (registers only).
  always_comb begin
    out_valid = '0;
    if (state_q == HOLD) begin
      out_valid = 10'b1 << sel_q;
    end
  end

  // Only the selected channel's ready can complete a delivery.
  assign deliver  = |(out_valid & out_ready);
  // Free slot, or the slot is being vacated this edge; nothing accepted in reset.
  assign in_ready = ~rst & ((state_q == EMPTY) | deliver);
  assign accept   = in_valid & in_ready;
  assign legal    = (in_sel <= 4'd9);

  // Next-state: a legal accept (re)loads the entry, otherwise a delivery empties it.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    err_sel_d   = 1'b0;
    err_count_d = err_count_q;
    if (accept && legal) begin
      state_d = HOLD;
      data_d  = in_data;
      sel_d   = in_sel;
    end else if (deliver) begin
      state_d = EMPTY;
    end
    if (accept && !legal) begin
      err_sel_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // State and entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      sel_q       <= '0;
      err_sel_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      err_sel_q   <= err_sel_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_data  = data_q;
  assign err_sel   = err_sel_q;
  assign err_count = err_count_q;
  assign dbg_full  = (state_q == HOLD);

endmodule

// File: tb/tb_demux_1to10.sv
// tb_demux_1to10: directed vector table plus randomized traffic against a queue model.
module tb_demux_1to10;
  localparam int W = 8;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] in_data;
  logic [3:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [9:0]   out_valid;
  logic [9:0]   out_ready;
  logic         err_sel;
  logic [7:0]   err_count;
  logic         dbg_full;

  demux_1to10 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel),
    .err_count(err_count), .dbg_full(dbg_full)
  );

  // Reference model: the held entry is a queue of at most one word.
  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   sel;
  } entry_t;

  entry_t       m_q[$];
  logic [W-1:0] m_data;
  int           m_cnt;
  bit           m_err;

  int   checks;
  int   failures;
  logic ir_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, check the combinational handshake before
  // the edge, advance the model across the edge, then check registered outputs.
  task automatic cycle(input logic r, input logic v, input logic [3:0] s,
                       input logic [W-1:0] d, input logic [9:0] o);
    logic       m_ir;
    logic [9:0] m_del;
    logic [9:0] m_ov;
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = o;
    #1;
    m_del = '0;
    if (m_q.size() != 0 && o[m_q[0].sel]) m_del = 10'b1 << m_q[0].sel;
    m_ir = !r && (m_q.size() == 0 || m_del != 0);
    ir_seen = in_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_ir});
    chk("delivery", {22'b0, out_valid & out_ready}, {22'b0, m_del});
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_data = '0;
      m_cnt  = 0;
      m_err  = 0;
    end else begin
      m_err = 0;
      if (m_del != 0) void'(m_q.pop_front());
      if (v && m_ir) begin
        if (s < 4'd10) begin
          m_q.push_back('{data: d, sel: s});
          m_data = d;
        end else begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    #1;
    m_ov = '0;
    if (m_q.size() != 0) m_ov = 10'b1 << m_q[0].sel;
    chk("out_valid", {22'b0, out_valid}, {22'b0, m_ov});
    chk("out_data", {24'b0, out_data}, {24'b0, m_data});
    chk("err_sel", {31'b0, err_sel}, {31'b0, m_err});
    chk("err_count", {24'b0, err_count}, m_cnt);
  endtask

  // Directed vectors: inputs for one cycle, in_ready before the edge, outputs after.
  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] s;
    logic [7:0] d;
    logic [9:0] o;
    logic       eir;
    logic [9:0] eov;
    logic [7:0] eod;
    logic       ees;
    logic [7:0] eec;
  } vec_t;

  vec_t tbl[23];

  initial begin
    checks = 0; failures = 0;
    m_data = '0; m_cnt = 0; m_err = 0;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    @(posedge clk);
    #1;

    // reset, single transfer to channel 3
    tbl[0]  = '{1, 0, 4'd0,  8'h00, 10'h3FF, 0, 10'h000, 8'h00, 0, 8'd0};
    tbl[1]  = '{0, 1, 4'd3,  8'hA5, 10'h3FF, 1, 10'h008, 8'hA5, 0, 8'd0};
    tbl[2]  = '{0, 0, 4'd0,  8'h00, 10'h3FF, 1, 10'h000, 8'hA5, 0, 8'd0};
    // backpressure on channel 7 for four cycles
    tbl[3]  = '{0, 1, 4'd7,  8'h11, 10'h3FF, 1, 10'h080, 8'h11, 0, 8'd0};
    tbl[4]  = '{0, 0, 4'd0,  8'h00, 10'h37F, 0, 10'h080, 8'h11, 0, 8'd0};
    tbl[5]  = '{0, 0, 4'd0,  8'h00, 10'h37F, 0, 10'h080, 8'h11, 0, 8'd0};
    tbl[6]  = '{0, 0, 4'd0,  8'h00, 10'h37F, 0, 10'h080, 8'h11, 0, 8'd0};
    tbl[7]  = '{0, 0, 4'd0,  8'h00, 10'h37F, 0, 10'h080, 8'h11, 0, 8'd0};
    tbl[8]  = '{0, 0, 4'd0,  8'h00, 10'h3FF, 1, 10'h000, 8'h11, 0, 8'd0};
    // wrong-channel ready while holding for channel 2
    tbl[9]  = '{0, 1, 4'd2,  8'h22, 10'h3FF, 1, 10'h004, 8'h22, 0, 8'd0};
    tbl[10] = '{0, 0, 4'd0,  8'h00, 10'h3FB, 0, 10'h004, 8'h22, 0, 8'd0};
    tbl[11] = '{0, 0, 4'd0,  8'h00, 10'h3FB, 0, 10'h004, 8'h22, 0, 8'd0};
    tbl[12] = '{0, 0, 4'd0,  8'h00, 10'h3FF, 1, 10'h000, 8'h22, 0, 8'd0};
    // illegal select 12: dropped, one-cycle error pulse
    tbl[13] = '{0, 1, 4'd12, 8'h55, 10'h3FF, 1, 10'h000, 8'h22, 1, 8'd1};
    tbl[14] = '{0, 0, 4'd0,  8'h00, 10'h3FF, 1, 10'h000, 8'h22, 0, 8'd1};
    // reset while holding for channel 5
    tbl[15] = '{0, 1, 4'd5,  8'h5C, 10'h000, 1, 10'h020, 8'h5C, 0, 8'd1};
    tbl[16] = '{0, 0, 4'd0,  8'h00, 10'h000, 0, 10'h020, 8'h5C, 0, 8'd1};
    tbl[17] = '{1, 0, 4'd0,  8'h00, 10'h000, 0, 10'h000, 8'h00, 0, 8'd0};
    tbl[18] = '{0, 0, 4'd0,  8'h00, 10'h000, 1, 10'h000, 8'h00, 0, 8'd0};
    // deliver + reload without a bubble, then illegal accept with delivery
    tbl[19] = '{0, 1, 4'd1,  8'h31, 10'h3FF, 1, 10'h002, 8'h31, 0, 8'd0};
    tbl[20] = '{0, 1, 4'd8,  8'h38, 10'h3FF, 1, 10'h100, 8'h38, 0, 8'd0};
    tbl[21] = '{0, 1, 4'd15, 8'h77, 10'h3FF, 1, 10'h000, 8'h38, 1, 8'd1};
    tbl[22] = '{0, 0, 4'd0,  8'h00, 10'h3FF, 1, 10'h000, 8'h38, 0, 8'd1};

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].o);
      chk($sformatf("v%0d_in_ready", i), {31'b0, ir_seen}, {31'b0, tbl[i].eir});
      chk($sformatf("v%0d_out_valid", i), {22'b0, out_valid}, {22'b0, tbl[i].eov});
      chk($sformatf("v%0d_out_data", i), {24'b0, out_data}, {24'b0, tbl[i].eod});
      chk($sformatf("v%0d_err_sel", i), {31'b0, err_sel}, {31'b0, tbl[i].ees});
      chk($sformatf("v%0d_err_count", i), {24'b0, err_count}, {24'b0, tbl[i].eec});
    end

    // Back-to-back: one word per cycle to channels 0..9, then drain.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 4'(i), 8'(i), 10'h3FF);
      chk($sformatf("b2b_ready%0d", i), {31'b0, ir_seen}, 32'd1);
      chk($sformatf("b2b_chan%0d", i), {22'b0, out_valid}, 32'(1) << i);
      chk($sformatf("b2b_data%0d", i), {24'b0, out_data}, i);
    end
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 10'h3FF);

    // Saturation: 260 illegal words from a count of 1.
    for (int i = 0; i < 260; i++) begin
      cycle(1'b0, 1'b1, 4'd12, 8'h55, 10'h3FF);
    end
    chk("err_count_sat", {24'b0, err_count}, 32'd255);
    cycle(1'b0, 1'b0, 4'd0, 8'h00, 10'h3FF);
    chk("err_count_hold", {24'b0, err_count}, 32'd255);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       v;
      logic [3:0] s;
      logic [9:0] o;
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      o = ($urandom_range(0, 1) == 0) ? 10'h3FF : 10'($urandom());
      cycle(r, v, s, 8'($urandom()), o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
